// File: rtl/seq_pattern_tx_if.sv
// Handshake and serial-output bundle for seq_pattern_tx.
// master drives burst requests, slave is the transmitter.
interface seq_pattern_tx_if #(
    parameter int PAT_W = 5
);
    logic             start;
    logic             use_default;
    logic [PAT_W-1:0] pat_in;
    logic [3:0]       rep_cnt;
    logic             ser_out;
    logic             ser_vld;
    logic             frame_start;
    logic             busy;
    logic             done;

    modport master (
        output start, use_default, pat_in, rep_cnt,
        input  ser_out, ser_vld, frame_start, busy, done
    );

    modport slave (
        input  start, use_default, pat_in, rep_cnt,
        output ser_out, ser_vld, frame_start, busy, done
    );
endinterface

// File: rtl/seq_pattern_tx.sv
// Repeating serial pattern transmitter, MSB first, with idle gaps.
// Define SEQ_TX_PARITY_EN to append an even-parity bit to every frame.
module seq_pattern_tx #(
    parameter int               PAT_W    = 5,
    parameter logic [PAT_W-1:0] PATTERN  = 5'b11101,
    parameter int               GAP_LEN  = 1,
    parameter logic             IDLE_BIT = 1'b0
) (
    input logic             clk,
    input logic             rst,
    seq_pattern_tx_if.slave bus
);

    localparam logic [3:0] BIT_LAST = 4'(PAT_W - 1);
    localparam logic [3:0] GAP_LAST = 4'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
`ifdef SEQ_TX_PARITY_EN
        PAR,
`endif
        GAP,
        DONE
    } state_t;

    state_t           state_q;
    logic [PAT_W-1:0] pat_q;
    logic [PAT_W-1:0] sh_q;
    logic [3:0]       bit_q;
    logic [3:0]       rep_q;
    logic [3:0]       gap_q;
    logic             ser_out_q;
    logic             ser_vld_q;
    logic             frame_start_q;
    logic             busy_q;
    logic             done_q;

    logic [PAT_W-1:0] pat_sel_d;
    logic [PAT_W-1:0] src_d;
    logic [3:0]       rep_eff_d;
    logic             frame_end_d;
    logic             more_d;
    logic             load_d;

    // Pattern source selection and frame-boundary decisions.
    always_comb begin
        pat_sel_d = bus.use_default ? PATTERN : bus.pat_in;
        rep_eff_d = (bus.rep_cnt == 4'd0) ? 4'd1 : bus.rep_cnt;
        src_d     = (state_q == IDLE) ? pat_sel_d : pat_q;
        more_d    = rep_q > 4'd1;
`ifdef SEQ_TX_PARITY_EN
        frame_end_d = (state_q == PAR);
`else
        frame_end_d = (state_q == SHIFT) && (bit_q == 4'd0);
`endif
        load_d = ((state_q == IDLE) && bus.start)
              || ((state_q == GAP) && (gap_q == 4'd0))
              || (frame_end_d && more_d && (GAP_LEN == 0));
    end

    // Burst FSM with registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            pat_q         <= '0;
            sh_q          <= '0;
            bit_q         <= 4'd0;
            rep_q         <= 4'd0;
            gap_q         <= 4'd0;
            ser_out_q     <= IDLE_BIT;
            ser_vld_q     <= 1'b0;
            frame_start_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            frame_start_q <= 1'b0;
            done_q        <= 1'b0;
            if ((state_q == IDLE) && bus.start) begin
                pat_q <= pat_sel_d;
                rep_q <= rep_eff_d;
            end else if (frame_end_d && (rep_q != 4'd0)) begin
                rep_q <= rep_q - 4'd1;
            end
            if (load_d) begin
                state_q       <= SHIFT;
                sh_q          <= src_d << 1;
                bit_q         <= BIT_LAST;
                ser_out_q     <= src_d[PAT_W-1];
                ser_vld_q     <= 1'b1;
                frame_start_q <= 1'b1;
                busy_q        <= 1'b1;
            end else if (frame_end_d) begin
                ser_vld_q <= 1'b0;
                ser_out_q <= IDLE_BIT;
                if (more_d) begin
                    state_q <= GAP;
                    gap_q   <= GAP_LAST;
                end else begin
                    state_q <= DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                end
            end else begin
                case (state_q)
                    SHIFT: begin
`ifdef SEQ_TX_PARITY_EN
                        if (bit_q == 4'd0) begin
                            state_q   <= PAR;
                            ser_out_q <= ^pat_q;
                        end else
`endif
                        begin
                            ser_out_q <= sh_q[PAT_W-1];
                            sh_q      <= sh_q << 1;
                            bit_q     <= bit_q - 4'd1;
                        end
                    end
                    GAP:     gap_q   <= gap_q - 4'd1;
                    DONE:    state_q <= IDLE;
                    default: ;
                endcase
            end
        end
    end

    assign bus.ser_out     = ser_out_q;
    assign bus.ser_vld     = ser_vld_q;
    assign bus.frame_start = frame_start_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx: one DUT with GAP_LEN=1,
// one with GAP_LEN=0, expected per-cycle outputs queued per DUT.
module tb_seq_pattern_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       use_default;
    logic [4:0] pat_in;
    logic [3:0] rep_cnt;

    always #5 clk = ~clk;

    seq_pattern_tx_if #(.PAT_W(5)) bus0 ();
    seq_pattern_tx_if #(.PAT_W(5)) bus1 ();

    assign bus0.start       = start;
    assign bus0.use_default = use_default;
    assign bus0.pat_in      = pat_in;
    assign bus0.rep_cnt     = rep_cnt;
    assign bus1.start       = start;
    assign bus1.use_default = use_default;
    assign bus1.pat_in      = pat_in;
    assign bus1.rep_cnt     = rep_cnt;

    seq_pattern_tx #(
        .PAT_W(5), .PATTERN(5'b11101), .GAP_LEN(1), .IDLE_BIT(1'b0)
    ) dut0 (
        .clk(clk), .rst(rst), .bus(bus0.slave)
    );

    seq_pattern_tx #(
        .PAT_W(5), .PATTERN(5'b11101), .GAP_LEN(0), .IDLE_BIT(1'b0)
    ) dut1 (
        .clk(clk), .rst(rst), .bus(bus1.slave)
    );

    typedef struct packed {
        logic v;
        logic d;
        logic f;
        logic b;
        logic n;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;
    int   det_cnt = 0;
    logic [4:0] det = 5'd0;

    string F, C, V, Z, S;

    function automatic void chk(string nm, logic act, logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b want %b", nm, $time, act, exp);
        end
    endfunction

    function automatic void cmp(string tag, exp_t e, exp_t a);
        chk({tag, ".ser_vld"}, a.v, e.v);
        chk({tag, ".ser_out"}, a.d, e.d);
        chk({tag, ".frame_start"}, a.f, e.f);
        chk({tag, ".busy"}, a.b, e.b);
        chk({tag, ".done"}, a.n, e.n);
    endfunction

    // Monitor for the GAP_LEN=1 transmitter.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q0.size() != 0) begin
            e = q0.pop_front();
            a = '{bus0.ser_vld, bus0.ser_out, bus0.frame_start,
                  bus0.busy, bus0.done};
            cmp("dut0", e, a);
        end
    end

    // Monitor for the GAP_LEN=0 transmitter.
    always @(negedge clk) begin
        exp_t e;
        exp_t a;
        if (q1.size() != 0) begin
            e = q1.pop_front();
            a = '{bus1.ser_vld, bus1.ser_out, bus1.frame_start,
                  bus1.busy, bus1.done};
            cmp("dut1", e, a);
        end
    end

    // 11101 detector on the valid bits of dut0.
    always @(negedge clk) begin
        if (bus0.ser_vld === 1'b1) begin
            det = {det[3:0], bus0.ser_out};
            if (det == 5'b11101) det_cnt++;
        end
    end

    function automatic logic b1(byte c);
        return c == 8'h31;
    endfunction

    task automatic push(int w, string v, string d, string f,
                        string b, string n);
        exp_t e;
        for (int i = 0; i < v.len(); i++) begin
            e = '{b1(v[i]), b1(d[i]), b1(f[i]), b1(b[i]), b1(n[i])};
            if (w == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
    endtask

    task automatic single(int w, string fr);
        push(w, {"0", V, "00"}, {"0", fr, "00"}, {"0", S, "00"},
             {"0", V, "00"}, {"0", Z, "10"});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go(logic ud, logic [4:0] p, logic [3:0] r);
        use_default = ud;
        pat_in      = p;
        rep_cnt     = r;
        start       = 1'b1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL drain timeout: left %0d/%0d want 0",
                     q0.size(), q1.size());
            q0.delete();
            q1.delete();
        end
        step();
    endtask

    initial begin
        int base;
`ifdef SEQ_TX_PARITY_EN
        F = "111010"; C = "101101"; V = "111111";
        Z = "000000"; S = "100000";
`else
        F = "11101"; C = "10110"; V = "11111";
        Z = "00000"; S = "10000";
`endif
        rst = 1'b1;
        start = 1'b0;
        use_default = 1'b1;
        pat_in = 5'b00000;
        rep_cnt = 4'd1;

        step();
        push(0, "00", "00", "00", "00", "00");
        push(1, "00", "00", "00", "00", "00");
        step();
        rst = 1'b0;
        drain();

        // single default frame
        go(1'b1, 5'b00000, 4'd1);
        single(0, F);
        single(1, F);
        step();
        start = 1'b0;
        drain();

        // two repetitions
        base = det_cnt;
        go(1'b1, 5'b00000, 4'd2);
        push(0, {"0", V, "0", V, "00"}, {"0", F, "0", F, "00"},
             {"0", S, "0", S, "00"}, {"0", V, "1", V, "00"},
             {"0", Z, "0", Z, "10"});
        push(1, {"0", V, V, "00"}, {"0", F, F, "00"},
             {"0", S, S, "00"}, {"0", V, V, "00"},
             {"0", Z, Z, "10"});
        step();
        start = 1'b0;
        drain();
        checks++;
        if (det_cnt - base != 2) begin
            errors++;
            $display("FAIL detections: got %0d want 2", det_cnt - base);
        end

        // rep_cnt 0 behaves as one frame
        go(1'b1, 5'b00000, 4'd0);
        single(0, F);
        single(1, F);
        step();
        start = 1'b0;
        drain();

        // three repetitions
        go(1'b1, 5'b00000, 4'd3);
        push(0, {"0", V, "0", V, "0", V, "00"},
             {"0", F, "0", F, "0", F, "00"},
             {"0", S, "0", S, "0", S, "00"},
             {"0", V, "1", V, "1", V, "00"},
             {"0", Z, "0", Z, "0", Z, "10"});
        push(1, {"0", V, V, V, "00"}, {"0", F, F, F, "00"},
             {"0", S, S, S, "00"}, {"0", V, V, V, "00"},
             {"0", Z, Z, Z, "10"});
        step();
        start = 1'b0;
        drain();

        // restart and input changes mid-burst are ignored
        go(1'b1, 5'b00000, 4'd1);
        single(0, F);
        single(1, F);
        step();
        start = 1'b0;
        step();
        use_default = 1'b0;
        pat_in = 5'b01010;
        rep_cnt = 4'd5;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        use_default = 1'b1;
        rep_cnt = 4'd1;
        drain();

        // reset mid-frame aborts without done
        go(1'b1, 5'b00000, 4'd1);
        push(0, "011100000", "011100000", "010000000",
             "011100000", "000000000");
        push(1, "011100000", "011100000", "010000000",
             "011100000", "000000000");
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        drain();

        // start coincident with reset is discarded
        rst = 1'b1;
        go(1'b1, 5'b00000, 4'd1);
        push(0, "000000", "000000", "000000", "000000", "000000");
        push(1, "000000", "000000", "000000", "000000", "000000");
        step();
        start = 1'b0;
        rst = 1'b0;
        drain();

        // external pattern
        go(1'b0, 5'b10110, 4'd1);
        single(0, C);
        single(1, C);
        step();
        start = 1'b0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_pattern_tx.md
SEQ_PATTERN_TX -- requirements
Module: seq_pattern_tx

Interface
- REQ-001: Parameter PAT_W, default 5; pattern width in bits, range 2..16.
- REQ-002: Parameter PATTERN, default 5'b11101; built-in pattern, transmitted MSB first.
- REQ-003: Parameter GAP_LEN, default 1; number of idle cycles between repetitions, range 0..15.
- REQ-004: Parameter IDLE_BIT, default 1'b0; value driven on ser_out whenever ser_vld=0.
- REQ-005: clk  input  1  clock; all logic on posedge.
- REQ-006: rst  input  1  reset, synchronous, active-high.
- REQ-007: start  input  1  request one transmission burst; sampled only in IDLE.
- REQ-008: use_default  input  1  1 selects PATTERN, 0 selects pat_in; sampled with start.
- REQ-009: pat_in  input  PAT_W  external pattern; sampled with start.
- REQ-010: rep_cnt  input  4  number of frame repetitions; 0 is treated as 1; sampled with start.
- REQ-011: ser_out  output  1  serial data, registered.
- REQ-012: ser_vld  output  1  ser_out carries a frame bit this cycle, registered.
- REQ-013: frame_start  output  1  high with the first (MSB) bit of every frame.
- REQ-014: busy  output  1  high from the cycle after start acceptance until the last frame bit has been driven.
- REQ-015: done  output  1  one-cycle pulse after the last bit of the last frame.

Function
- REQ-016: States SHALL be IDLE, SHIFT, PAR (parity, macro only), GAP, DONE.
- REQ-017: In IDLE with start=1, the block SHALL latch the selected pattern and the effective repeat count, then enter SHIFT on the next edge.
- REQ-018: The first frame bit SHALL appear on ser_out exactly one cycle after the edge at which start was sampled.
- REQ-019: SHIFT SHALL drive one pattern bit per cycle, MSB first, with ser_vld=1, for exactly PAT_W cycles.
- REQ-020: After the last bit of a frame, the block SHALL enter GAP if repetitions remain and GAP_LEN>0, enter SHIFT directly if repetitions remain and GAP_LEN=0, and otherwise enter DONE.
- REQ-021: GAP SHALL last exactly GAP_LEN cycles with ser_vld=0 and ser_out=IDLE_BIT, then return to SHIFT.
- REQ-022: When GAP_LEN=0, frames SHALL be back-to-back with no ser_vld deassertion.
- REQ-023: DONE SHALL last one cycle with done=1, busy=0 and ser_vld=0, then return to IDLE.
- REQ-024: start SHALL be ignored in SHIFT, PAR, GAP and DONE; no queuing.
- REQ-025: Changes to pat_in, use_default or rep_cnt after acceptance SHALL NOT affect the burst in progress.
- REQ-026: The bit counter SHALL be wide enough for PAT_W=16; the repeat counter SHALL be 4 bits and SHALL decrement once per completed frame without wrap.

Reset
- REQ-027: rst=1 SHALL force IDLE on the next edge, regardless of the current state, including mid-frame.
- REQ-028: Reset values SHALL be: ser_out=IDLE_BIT, ser_vld=0, frame_start=0, busy=0, done=0, all counters 0.
- REQ-029: A start coincident with rst=1 SHALL be discarded.
- REQ-030: No done pulse SHALL be produced for a burst aborted by reset.

Configuration
- REQ-031: Macro SEQ_TX_PARITY_EN, when defined, SHALL add the PAR state after the last SHIFT bit of every frame, driving the even-parity bit (XOR of all pattern bits) with ser_vld=1, so that each frame is PAT_W+1 valid bits.
- REQ-032: Without SEQ_TX_PARITY_EN, PAR SHALL NOT exist, and each frame SHALL be exactly PAT_W valid bits.

Verification
- REQ-033: Default build, use_default=1, rep_cnt=1, start pulse at cycle 0 -> ser_out=1,1,1,0,1 with ser_vld=1 in cycles 1-5, frame_start in cycle 1, done in cycle 6, busy in cycles 1-5.
- REQ-034: rep_cnt=2, GAP_LEN=1 -> 11101, one idle cycle (ser_vld=0, ser_out=0), 11101, done in cycle 12; feeding the 11101 detector FSM yields two detections.
- REQ-035: rep_cnt=0 -> exactly one frame; GAP_LEN=0 with rep_cnt=3 -> 15 consecutive valid bits, done in cycle 16.
- REQ-036: start re-asserted in cycle 3 of a burst -> ignored, output identical to REQ-033; rst asserted in cycle 3 -> IDLE with ser_vld=0 next cycle and no done pulse.
- REQ-037: SEQ_TX_PARITY_EN defined, use_default=0, pat_in=5'b10110 -> 1,0,1,1,0,1 in cycles 1-6, done in cycle 7; default pattern 11101 -> parity bit 0.
